// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (IF) and memory access (MA)
// share one memory port with MA priority and a bounded IF starvation window.
module mem_arbiter #(
   parameter int AW           = 64,
   parameter int DW           = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   output logic [DW-1:0]   if_rdata,
   input  logic            ma_req,
   input  logic            ma_we,
   input  logic [AW-1:0]   ma_addr,
   input  logic [DW-1:0]   ma_wdata,
   input  logic [DW/8-1:0] ma_be,
   output logic            ma_gnt,
   output logic            ma_rvalid,
   output logic [DW-1:0]   ma_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic            mem_ack,
   input  logic [DW-1:0]   mem_rdata,
   output logic            busy
);

   localparam int BW = DW / 8;
   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_MA
   } state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            we_q, we_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [BW-1:0]   be_q, be_d;
   logic [DW-1:0]   if_rdata_q, if_rdata_d;
   logic [DW-1:0]   ma_rdata_q, ma_rdata_d;
   logic            if_rvalid_q, if_rvalid_d;
   logic            ma_rvalid_q, ma_rvalid_d;
   logic            if_win, ma_win;

   // Arbitration, request capture and completion handling.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      if_rdata_d  = if_rdata_q;
      ma_rdata_d  = ma_rdata_q;
      if_rvalid_d = 1'b0;
      ma_rvalid_d = 1'b0;
      if_win      = 1'b0;
      ma_win      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (if_req && (!ma_req || starve_q == LIMIT)) begin
               if_win   = 1'b1;
               state_d  = BUSY_IF;
               starve_d = '0;
               addr_d   = if_addr;
               we_d     = 1'b0;
               wdata_d  = '0;
               be_d     = '1;
            end else if (ma_req) begin
               ma_win   = 1'b1;
               state_d  = BUSY_MA;
               addr_d   = ma_addr;
               we_d     = ma_we;
               wdata_d  = ma_wdata;
               be_d     = ma_be;
               if (!if_req)
                  starve_d = '0;
               else if (starve_q != LIMIT)
                  starve_d = starve_q + SW'(1);
            end
         end
         BUSY_IF: begin
            if (mem_ack) begin
               state_d     = IDLE;
               if_rvalid_d = 1'b1;
               if_rdata_d  = mem_rdata;
            end
         end
         BUSY_MA: begin
            if (mem_ack) begin
               state_d     = IDLE;
               ma_rvalid_d = 1'b1;
               if (!we_q)
                  ma_rdata_d = mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         be_q        <= '0;
         if_rdata_q  <= '0;
         ma_rdata_q  <= '0;
         if_rvalid_q <= 1'b0;
         ma_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         if_rdata_q  <= if_rdata_d;
         ma_rdata_q  <= ma_rdata_d;
         if_rvalid_q <= if_rvalid_d;
         ma_rvalid_q <= ma_rvalid_d;
      end
   end

   // Outputs are forced low while reset is asserted.
   assign if_gnt    = if_win & ~rst;
   assign ma_gnt    = ma_win & ~rst;
   assign if_rvalid = if_rvalid_q & ~rst;
   assign ma_rvalid = ma_rvalid_q & ~rst;
   assign if_rdata  = rst ? '0 : if_rdata_q;
   assign ma_rdata  = rst ? '0 : ma_rdata_q;
   assign busy      = (state_q != IDLE) & ~rst;
   assign mem_req   = busy;
   assign mem_we    = we_q & ~rst;
   assign mem_addr  = rst ? '0 : addr_q;
   assign mem_wdata = rst ? '0 : wdata_q;
   assign mem_be    = rst ? '0 : be_q;

endmodule
